// File: rtl/ode_seq_pkg.sv
// Shared definitions for the ODE step sequencer: register map, bit positions
// and the sequencer state encoding.
package ode_seq_pkg;

  // Avalon register addresses
  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_STEPS     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD    = 3'd2;
  localparam logic [2:0] ADDR_STATUS    = 3'd3;
  localparam logic [2:0] ADDR_REMAINING = 3'd4;

  // CTRL bit positions (start/abort are strobes, continuous/irq_en are stored)
  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_CONT   = 2;
  localparam int CTRL_IRQ_EN = 3;

  // STATUS bit positions (busy is live, done/aborted are write-one-to-clear)
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ode_seq_timer.sv
// Pulse-period down-counter. Load has priority over counting; tc flags the
// last WAIT cycle (count == 1) so the sequencer can move to PULSE.
module ode_seq_timer
  import ode_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count;

  // Load or decrement the period counter; it parks at zero when exhausted.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == W'(1));

endmodule

// File: rtl/ode_step_sequencer.sv
// Avalon-MM slave that issues N single-cycle clk_en pulses to the ODE solver
// datapath, spaced by a programmable period and throttled by dp_ready.
//
// Handshake: a clk_en pulse is one cycle wide. After each pulse the sequencer
// sits in HOLD and advances only on a cycle where dp_ready is 1 (dp_ready is
// never looked at during the pulse cycle itself). The bus side is a
// zero-wait-state Avalon slave: a write is chipselect & ~write_n sampled on the
// rising edge; readdata is purely combinational from address.
module ode_step_sequencer
  import ode_seq_pkg::*;
#(
  parameter int STEP_W   = 32,
  parameter int PERIOD_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        dp_ready,
  output logic        clk_en,
  output logic        irq
);

  // Programmed registers
  logic [STEP_W-1:0]   steps_reg;
  logic [PERIOD_W-1:0] period_reg;
  logic                continuous;
  logic                irq_en;

  // Run state
  seq_state_e          state;
  seq_state_e          state_next;
  logic [STEP_W-1:0]   remaining;
  logic [PERIOD_W-1:0] period_work;
  logic                done;
  logic                aborted;

  // Decoded bus strobes
  logic wr;
  logic ctrl_wr;
  logic status_wr;
  logic start_req;
  logic abort_req;

  // FSM control strobes
  logic                start_run;
  logic                dec_rem;
  logic                set_done;
  logic                set_aborted;
  logic                timer_load;
  logic                timer_tc;
  logic [PERIOD_W-1:0] period_eff;
  logic [PERIOD_W-1:0] timer_value;
  logic                busy;

  assign wr        = chipselect & ~write_n;
  assign ctrl_wr   = wr && (address == ADDR_CTRL);
  assign status_wr = wr && (address == ADDR_STATUS);
  assign start_req = ctrl_wr & writedata[CTRL_START];
  assign abort_req = ctrl_wr & writedata[CTRL_ABORT];

  // A programmed period of zero behaves like one.
  assign period_eff  = (period_reg == '0) ? PERIOD_W'(1) : period_reg;
  // First load of a run takes the programmed period; reloads reuse the copy.
  assign timer_value = (state == S_IDLE) ? period_eff : period_work;

  assign busy = (state != S_IDLE);

  ode_seq_timer #(.W(PERIOD_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .en         (state == S_WAIT),
    .tc         (timer_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control strobes; abort beats every other transition.
  always_comb begin
    state_next  = state;
    start_run   = 1'b0;
    dec_rem     = 1'b0;
    set_done    = 1'b0;
    set_aborted = 1'b0;
    timer_load  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_req && !abort_req) begin
          // The continuous bit written alongside start governs this start.
          if ((steps_reg != '0) || writedata[CTRL_CONT]) begin
            start_run  = 1'b1;
            timer_load = 1'b1;
            state_next = S_WAIT;
          end else begin
            set_done = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (abort_req) begin
          set_aborted = 1'b1;
          state_next  = S_IDLE;
        end else if (timer_tc) begin
          state_next = S_PULSE;
        end
      end
      S_PULSE: begin
        if (abort_req) begin
          set_aborted = 1'b1;
          state_next  = S_IDLE;
        end else begin
          // Guard against wrap when continuous was dropped with nothing left.
          dec_rem    = !continuous && (remaining != '0);
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (abort_req) begin
          set_aborted = 1'b1;
          state_next  = S_IDLE;
        end else if (dp_ready) begin
          if ((remaining == '0) && !continuous) begin
            set_done   = 1'b1;
            state_next = S_IDLE;
          end else begin
            timer_load = 1'b1;
            state_next = S_WAIT;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Programmable registers written from the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      steps_reg  <= '0;
      period_reg <= '0;
      continuous <= 1'b0;
      irq_en     <= 1'b0;
    end else if (wr) begin
      case (address)
        ADDR_CTRL: begin
          continuous <= writedata[CTRL_CONT];
          irq_en     <= writedata[CTRL_IRQ_EN];
        end
        ADDR_STEPS:  steps_reg  <= writedata[STEP_W-1:0];
        ADDR_PERIOD: period_reg <= writedata[PERIOD_W-1:0];
        default: ;
      endcase
    end
  end

  // Working counters and sticky flags; a hardware set outranks a W1C clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining   <= '0;
      period_work <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      if (start_run) begin
        remaining   <= steps_reg;
        period_work <= period_eff;
      end else if (dec_rem) begin
        remaining <= remaining - STEP_W'(1);
      end

      if (set_done) begin
        done <= 1'b1;
      end else if (start_run) begin
        done <= 1'b0;
      end else if (status_wr && writedata[STAT_DONE]) begin
        done <= 1'b0;
      end

      if (set_aborted) begin
        aborted <= 1'b1;
      end else if (start_run) begin
        aborted <= 1'b0;
      end else if (status_wr && writedata[STAT_ABORTED]) begin
        aborted <= 1'b0;
      end
    end
  end

  // Zero-wait-state read mux; unmapped addresses read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_CONT]   = continuous;
        readdata[CTRL_IRQ_EN] = irq_en;
      end
      ADDR_STEPS:     readdata = 32'(steps_reg);
      ADDR_PERIOD:    readdata = 32'(period_reg);
      ADDR_STATUS: begin
        readdata[STAT_BUSY]    = busy;
        readdata[STAT_DONE]    = done;
        readdata[STAT_ABORTED] = aborted;
      end
      ADDR_REMAINING: readdata = 32'(remaining);
      default:        readdata = '0;
    endcase
  end

  // An abort landing on the pulse cycle suppresses that pulse.
  assign clk_en = (state == S_PULSE) && !abort_req && !reset;
  assign irq    = done & irq_en;

endmodule

// File: tb/tb_ode_step_sequencer.sv
// Directed bench for ode_step_sequencer: register access, pulse timing,
// dp_ready stall, continuous/abort, zero-step start and mid-run reset.
module tb_ode_step_sequencer;

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_STEPS = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_REM = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        dp_ready = 1'b0;
  logic        clk_en;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;

  // clock / reset block
  always #5 clk = ~clk;

  ode_step_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .dp_ready   (dp_ready),
    .clk_en     (clk_en),
    .irq        (irq)
  );

  // Pulse monitor, sampled mid-low-phase where all inputs are settled.
  always begin
    @(negedge clk);
    #2;
    if (clk_en === 1'b1) pulse_cnt++;
  end

  // Global time limit.
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not reach its end, observed running expected finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    #1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1;
    d = readdata;
  endtask

  initial begin
    logic [31:0] rd;
    logic        exp_en;
    int          base;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      check($sformatf("reset_read_a%0d", a), rd, 32'd0);
    end
    check("reset_clk_en", 32'(clk_en), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);

    // ---------------- N=3, PERIOD=2, irq_en ----------------
    dp_ready = 1'b1;
    bus_write(A_STEPS, 32'd3);
    bus_write(A_PERIOD, 32'd2);
    bus_read(A_STEPS, rd);
    check("steps_readback", rd, 32'd3);
    bus_read(A_PERIOD, rd);
    check("period_readback", rd, 32'd2);
    bus_write(A_CTRL, 32'h9);
    // Cycle 0 is the first cycle after the write edge; pulses at 2, 6, 10.
    for (int i = 0; i < 16; i++) begin
      exp_en = (i == 2) || (i == 6) || (i == 10);
      check($sformatf("run1_clk_en_c%0d", i), 32'(clk_en), 32'(exp_en));
      next_cycle();
    end
    bus_read(A_STATUS, rd);
    check("run1_status_done", rd, 32'h2);
    check("run1_irq_set", 32'(irq), 32'd1);
    bus_read(A_REM, rd);
    check("run1_remaining", rd, 32'd0);
    bus_read(A_CTRL, rd);
    check("run1_ctrl_read", rd, 32'h8);
    bus_write(A_STATUS, 32'h2);
    bus_read(A_STATUS, rd);
    check("run1_done_cleared", rd, 32'h0);
    check("run1_irq_cleared", 32'(irq), 32'd0);

    // ---------------- N=2, PERIOD=1, dp_ready stall ----------------
    bus_write(A_STEPS, 32'd2);
    bus_write(A_PERIOD, 32'd1);
    dp_ready = 1'b0;
    bus_write(A_CTRL, 32'h1);
    check("stall_c0_wait", 32'(clk_en), 32'd0);
    next_cycle();
    check("stall_first_pulse", 32'(clk_en), 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus_read(A_REM, rd);
      check($sformatf("stall_remaining_%0d", i), rd, 32'd1);
      check($sformatf("stall_no_pulse_%0d", i), 32'(clk_en), 32'd0);
    end
    dp_ready = 1'b1;
    next_cycle();
    check("stall_release_wait", 32'(clk_en), 32'd0);
    next_cycle();
    check("stall_second_pulse", 32'(clk_en), 32'd1);
    repeat (3) next_cycle();
    bus_read(A_STATUS, rd);
    check("stall_status_done", rd, 32'h2);
    check("stall_irq_masked", 32'(irq), 32'd0);
    bus_write(A_STATUS, 32'h2);

    // ---------------- continuous, N=0, then abort ----------------
    bus_write(A_STEPS, 32'd0);
    base = pulse_cnt;
    bus_write(A_CTRL, 32'h5);
    for (int k = 0; k < 40 && pulse_cnt < base + 1; k++) next_cycle();
    // Reprogram STEPS and retry start mid-run: both must leave the run alone.
    bus_write(A_STEPS, 32'd5);
    bus_write(A_CTRL, 32'h5);
    bus_read(A_REM, rd);
    check("cont_remaining_unchanged", rd, 32'd0);
    bus_read(A_STATUS, rd);
    check("cont_busy", rd, 32'h1);
    for (int k = 0; k < 60 && pulse_cnt < base + 5; k++) next_cycle();
    bus_write(A_CTRL, 32'h2);
    repeat (10) next_cycle();
    check("cont_pulse_total", 32'(pulse_cnt - base), 32'd5);
    bus_read(A_STATUS, rd);
    check("cont_status_aborted", rd, 32'h4);
    bus_read(A_CTRL, rd);
    check("cont_ctrl_after_abort", rd, 32'h0);

    // ---------------- zero-step start; start+abort in IDLE ----------------
    bus_write(A_STATUS, 32'h4);
    bus_write(A_STEPS, 32'd0);
    base = pulse_cnt;
    bus_write(A_CTRL, 32'h1);
    address = A_STATUS;
    #1;
    check("zero_done_next_cycle", readdata, 32'h2);
    repeat (6) next_cycle();
    check("zero_no_pulses", 32'(pulse_cnt - base), 32'd0);
    bus_write(A_STATUS, 32'h2);
    bus_write(A_STEPS, 32'd3);
    bus_write(A_CTRL, 32'h3);
    bus_read(A_STATUS, rd);
    check("start_abort_not_busy", rd, 32'h0);
    repeat (8) next_cycle();
    bus_read(A_STATUS, rd);
    check("start_abort_still_idle", rd, 32'h0);
    check("start_abort_no_pulses", 32'(pulse_cnt - base), 32'd0);

    // ---------------- reset during WAIT ----------------
    bus_write(A_PERIOD, 32'd3);
    bus_write(A_STEPS, 32'd4);
    bus_write(A_CTRL, 32'h9);
    reset = 1'b1;
    next_cycle();
    check("rst_wait_clk_en", 32'(clk_en), 32'd0);
    reset = 1'b0;
    for (int a = 0; a < 5; a++) begin
      bus_read(3'(a), rd);
      check($sformatf("rst_wait_read_a%0d", a), rd, 32'd0);
    end
    check("rst_wait_irq", 32'(irq), 32'd0);

    // ---------------- reset during PULSE ----------------
    bus_write(A_PERIOD, 32'd3);
    bus_write(A_STEPS, 32'd4);
    bus_write(A_CTRL, 32'h9);
    repeat (3) next_cycle();
    check("rst_pulse_pulse_seen", 32'(clk_en), 32'd1);
    reset = 1'b1;
    next_cycle();
    check("rst_pulse_clk_en", 32'(clk_en), 32'd0);
    reset = 1'b0;
    base = pulse_cnt;
    for (int a = 0; a < 5; a++) begin
      bus_read(3'(a), rd);
      check($sformatf("rst_pulse_read_a%0d", a), rd, 32'd0);
    end
    repeat (10) next_cycle();
    check("rst_pulse_no_more_pulses", 32'(pulse_cnt - base), 32'd0);
    check("rst_pulse_irq", 32'(irq), 32'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ode_step_sequencer.md
Name: ode_step_sequencer

Overview:
- Avalon-MM slave that sequences the ODE solver datapath's clock-enable.
- The NIOS II programs a step count and a pulse period, then starts a run. The block issues exactly N single-cycle clk_en pulses, each spaced by PERIOD cycles and gated by a datapath-ready handshake.
- On completion it sets a done flag and raises an interrupt.
- It replaces the CPU-toggled 1-bit enable PIO, so the CPU no longer times each solver step.

Parameters:
- STEP_W, 32, width of step count and remaining counter.
- PERIOD_W, 16, width of pulse-period counter.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- address  in  3  register select.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational from address, 0 wait states.
- dp_ready  in  1  datapath has finished the current step and can accept the next enable.
- clk_en  out  1  one-cycle enable pulse to the solver datapath.
- irq  out  1  level interrupt: done & irq_en.

Behaviour:
- Write = chipselect & ~write_n. All state updates on posedge clk. reset=1 forces every register to 0, state IDLE, clk_en=0, irq=0; this applies mid-run too, with no further pulses issued.
- Register map:
  - 0 CTRL (W): bit0 start, bit1 abort, bit2 continuous, bit3 irq_en. Bits 0/1 are self-clearing strobes; bits 2/3 are stored. Read returns {28'b0, irq_en, continuous, 2'b0}.
  - 1 STEPS (RW): N, width STEP_W, zero-extended on read.
  - 2 PERIOD (RW): width PERIOD_W. A value of 0 is treated as 1.
  - 3 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 aborted (W1C).
  - 4 REMAINING (RO).
  - Addresses 5-7 read 0; writes to them are ignored.
- At start, N and PERIOD are copied into working counters. Later writes to STEPS or PERIOD take effect only at the next start.
- FSM states: IDLE, WAIT, PULSE, HOLD.
  - IDLE:
    - start with N>0 or continuous=1: load remaining=N, pcnt=max(PERIOD,1), clear done and aborted, go to WAIT.
    - start with N=0 and continuous=0: set done, stay in IDLE, issue no pulse.
  - WAIT: decrement pcnt each cycle. When pcnt==1, go to PULSE. PERIOD=1 gives exactly 1 WAIT cycle.
  - PULSE: clk_en=1 for exactly this cycle. Decrement remaining unless continuous=1. Go to HOLD.
  - HOLD: wait for dp_ready=1; dp_ready is sampled from the cycle after PULSE onward.
    - If remaining==0 and continuous=0: go to IDLE and set done.
    - Otherwise: reload pcnt and go to WAIT.
- Pulse spacing with dp_ready held high: PERIOD+2 cycles between consecutive clk_en pulses.
- Latency from start write to first clk_en: PERIOD+1 cycles.
- busy = (state != IDLE).
- Start while busy is ignored.
- Abort in any non-IDLE state: go to IDLE next cycle, set aborted, leave done unchanged, issue no clk_en that cycle. Abort in IDLE has no effect.
- Start and abort in the same write: abort wins, and the run does not start.
- Hardware set of done/aborted in the same cycle as a W1C clear: the set wins.
- Clearing continuous while busy: the run ends at the next HOLD exit if remaining==0; otherwise it continues counting down from the current remaining value.
- irq is combinational from registered done and irq_en, with no glitch source.

Decomposition:
- Shared package ode_seq_pkg holds:
  - register address constants (ADDR_CTRL=0 … ADDR_REMAINING=4);
  - CTRL/STATUS bit-index constants;
  - FSM state enum (2-bit encoding).
- Natural sub-module: ode_seq_timer, the period down-counter with load, enable and terminal-count output. The Avalon register file and FSM stay in the top level.

Test Plan:
- Reset, then read all 5 addresses -> all return 0; clk_en=0, irq=0.
- STEPS=3, PERIOD=2, dp_ready=1, CTRL=0x9 -> first clk_en 3 cycles after the write, pulses 4 cycles apart, exactly 3 pulses. Then busy=0, STATUS=0x2, irq=1. Writing STATUS=0x2 clears done and irq.
- STEPS=2, PERIOD=1, dp_ready held low for 10 cycles after the first pulse -> no second pulse until dp_ready rises; REMAINING reads 1 while stalled.
- Continuous run with STEPS=0: start, 5 pulses, then CTRL=0x2 (abort) -> no further clk_en, STATUS=0x4, done=0. A second start while busy is ignored (verified mid-run).
- STEPS=0, continuous=0, start -> zero pulses, done=1 on the cycle after the write. CTRL=0x3 (start+abort) in IDLE -> no run, busy stays 0.
- reset asserted mid-run during WAIT and during PULSE -> clk_en=0 on the following cycle, all registers 0. Writing STEPS=5 mid-run leaves the current run's count unchanged.
